// File: rtl/pll_cfg_seq.sv
// PLL reconfiguration sequencer: writes mode/N/M/C0/START over the Avalon-MM
// management port, then supervises loss and reacquisition of lock with timeouts.
module pll_cfg_seq #(
    parameter int unsigned UNLOCK_WAIT  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_req,
    input  logic [17:0] cfg_n,
    input  logic [17:0] cfg_m,
    input  logic [17:0] cfg_c0,
    input  logic        pll_locked,
    output logic [5:0]  mgmt_addr,
    output logic [31:0] mgmt_wdata,
    output logic        mgmt_write,
    input  logic        mgmt_waitreq,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned MAXP = (UNLOCK_WAIT > LOCK_TIMEOUT) ? UNLOCK_WAIT : LOCK_TIMEOUT;
    localparam int unsigned CW   = (MAXP > 2) ? $clog2(MAXP) : 1;

    typedef enum logic [3:0] {
        IDLE, WR_MODE, WR_N, WR_M, WR_C0, WR_START, WAIT_UNLK, WAIT_LOCK, DONE, ERR
    } state_t;

    state_t        state, state_nx;
    logic          phase, phase_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [17:0]   n_q, m_q, c0_q;
    logic          latch, set_err;
    logic          lk_meta, lk_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_meta <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk_s    <= lk_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            phase <= 1'b0;
            cnt   <= '0;
            n_q   <= '0;
            m_q   <= '0;
            c0_q  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
            cnt   <= cnt_nx;
            if (latch) begin
                n_q  <= cfg_n;
                m_q  <= cfg_m;
                c0_q <= cfg_c0;
                err  <= 1'b0;
            end else if (set_err) begin
                err <= 1'b1;
            end
        end
    end

    // Each WR_* state spends its first cycle (phase=0) with write low, giving
    // the idle cycle between transactions; phase=1 holds the write until accepted.
    always_comb begin
        state_nx   = state;
        phase_nx   = 1'b0;
        cnt_nx     = '0;
        mgmt_addr  = '0;
        mgmt_wdata = '0;
        mgmt_write = 1'b0;
        latch      = 1'b0;
        set_err    = 1'b0;
        done       = 1'b0;
        busy       = (state != IDLE);

        case (state)
            WR_MODE:  begin mgmt_addr = 6'h00; mgmt_wdata = 32'd0;              end
            WR_N:     begin mgmt_addr = 6'h03; mgmt_wdata = {14'b0, n_q};       end
            WR_M:     begin mgmt_addr = 6'h04; mgmt_wdata = {14'b0, m_q};       end
            WR_C0:    begin mgmt_addr = 6'h05; mgmt_wdata = {9'b0, 5'd0, c0_q}; end
            WR_START: begin mgmt_addr = 6'h02; mgmt_wdata = 32'd1;              end
            default:  ;
        endcase

        case (state)
            IDLE: begin
                if (cfg_req) begin
                    state_nx = WR_MODE;
                    latch    = 1'b1;
                end
            end
            WR_MODE, WR_N, WR_M, WR_C0, WR_START: begin
                if (!phase) begin
                    phase_nx = 1'b1;
                end else begin
                    mgmt_write = 1'b1;
                    if (mgmt_waitreq) begin
                        phase_nx = 1'b1;
                    end else begin
                        case (state)
                            WR_MODE:  state_nx = WR_N;
                            WR_N:     state_nx = WR_M;
                            WR_M:     state_nx = WR_C0;
                            WR_C0:    state_nx = WR_START;
                            default:  state_nx = WAIT_UNLK;
                        endcase
                    end
                end
            end
            WAIT_UNLK: begin
                if (!lk_s || cnt == CW'(UNLOCK_WAIT - 1)) state_nx = WAIT_LOCK;
                else                                      cnt_nx   = cnt + 1'b1;
            end
            WAIT_LOCK: begin
                if (lk_s) begin
                    state_nx = DONE;
                end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    state_nx = ERR;
                    set_err  = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            ERR: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Self-checking bench for pll_cfg_seq: table vectors, randomized runs against a
// cycle-offset reference model, and a hand-written reset-during-write sequence.
module tb_pll_cfg_seq;

    localparam int unsigned UW = 1024;
    localparam int unsigned LT = 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_req = 1'b0;
    logic [17:0] cfg_n = '0, cfg_m = '0, cfg_c0 = '0;
    logic        pll_locked = 1'b1;
    logic [5:0]  mgmt_addr;
    logic [31:0] mgmt_wdata;
    logic        mgmt_write;
    logic        mgmt_waitreq = 1'b0;
    logic        busy, done, err;

    pll_cfg_seq #(.UNLOCK_WAIT(UW), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_req(cfg_req),
        .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_c0(cfg_c0),
        .pll_locked(pll_locked),
        .mgmt_addr(mgmt_addr), .mgmt_wdata(mgmt_wdata), .mgmt_write(mgmt_write),
        .mgmt_waitreq(mgmt_waitreq),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [17:0] n, m, c0;
        int          stall_lo, stall_hi;
        bit          lvl0;
        int          fall, rise;
        bit          poke;
        bit          exp_err;
        int          exp_off;
    } vec_t;

    // Scenario knobs shared with the background drivers
    int          stall_lo = 0, stall_hi = 0;
    bit          lvl0 = 1'b1;
    int          fall_off = 0, rise_off = 0;
    bit          start_valid = 1'b0;
    int          start_k = 0;
    int          cyc = 0;
    logic [37:0] wq[$];

    // Locked level t edges after START completes; fall/rise of 0 mean "never".
    function automatic bit lvl_at(input bit l0, input int f, input int r, input int t);
        if (t <= 0) return l0;
        if (f > 0 && t >= f) return (r > 0 && t >= f + r);
        return l0;
    endfunction

    // Reference: a locked change after edge x is first acted on at edge x+3.
    // Unlock wait ends on unlock or after UW edges; lock wait has LT edges,
    // and lock seen on the final edge still counts as success.
    task automatic predict(input bit l0, input int f, input int r,
                           output bit is_err, output int off);
        int eu;
        eu = UW;
        for (int j = 1; j <= int'(UW); j++)
            if (!lvl_at(l0, f, r, j - 3)) begin eu = j; break; end
        is_err = 1'b1;
        off    = eu + LT;
        for (int j = 1; j <= int'(LT); j++)
            if (lvl_at(l0, f, r, eu + j - 3)) begin is_err = 1'b0; off = eu + j; break; end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        pll_locked = start_valid ? lvl_at(lvl0, fall_off, rise_off, cyc - start_k) : lvl0;
    end

    // Waitrequest slave model plus transaction monitor and Avalon hold checks
    bit          in_write = 1'b0;
    int          stall_left = 0;
    bit          prev_hold = 1'b0;
    logic [5:0]  prev_addr;
    logic [31:0] prev_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_write     = 1'b0;
            mgmt_waitreq = 1'b0;
            prev_hold    = 1'b0;
        end else begin
            if (mgmt_write) begin
                if (!in_write) begin
                    in_write   = 1'b1;
                    stall_left = $urandom_range(stall_hi, stall_lo);
                end
                mgmt_waitreq = (stall_left > 0);
                if (stall_left > 0) stall_left--;
            end else begin
                in_write     = 1'b0;
                mgmt_waitreq = 1'b0;
            end
            if (prev_hold) begin
                chk("hold_write", mgmt_write, 1);
                chk("hold_addr", mgmt_addr, prev_addr);
                chk("hold_data", mgmt_wdata, prev_data);
            end
            if (mgmt_write) chk("write_only_when_busy", busy, 1);
            if (mgmt_write && !mgmt_waitreq) begin
                wq.push_back({mgmt_addr, mgmt_wdata});
                if (mgmt_addr == 6'h02) begin
                    start_k     = cyc + 1;
                    start_valid = 1'b1;
                end
            end
            prev_hold = mgmt_write && mgmt_waitreq;
            prev_addr = mgmt_addr;
            prev_data = mgmt_wdata;
        end
    end

    task automatic run(input vec_t v);
        logic [37:0] ew[5];
        int          edge_at;
        wq.delete();
        start_valid = 1'b0;
        stall_lo = v.stall_lo;
        stall_hi = v.stall_hi;
        lvl0     = v.lvl0;
        fall_off = v.fall;
        rise_off = v.rise;
        repeat (4) @(negedge clk);
        #1;
        cfg_n = v.n; cfg_m = v.m; cfg_c0 = v.c0;
        cfg_req = 1'b1;
        @(negedge clk); #1;
        cfg_req = 1'b0;
        chk("busy_after_accept", busy, 1);
        chk("err_cleared_on_accept", err, 0);
        cfg_n = ~v.n; cfg_m = ~v.m; cfg_c0 = ~v.c0;
        if (v.poke) begin
            repeat (3) @(negedge clk);
            #1;
            cfg_n = 18'h2AAAA; cfg_m = 18'h15555; cfg_c0 = 18'h3FFFF;
            cfg_req = 1'b1;
            @(negedge clk); #1;
            cfg_req = 1'b0;
        end
        for (int i = 0; i < 300 && !start_valid; i++) begin @(negedge clk); #1; end
        chk("start_written", start_valid, 1);
        edge_at = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (done || err) begin edge_at = cyc; break; end
        end
        chk("outcome_err", err, v.exp_err);
        chk("outcome_done", done, !v.exp_err);
        chk("outcome_cycle", edge_at - start_k, v.exp_off);
        @(negedge clk); #1;
        chk("done_one_cycle", done, 0);
        if (v.exp_err) chk("err_sticky", err, 1);
        else           chk("busy_low_after_done", busy, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("idle_after_run", busy, 0);
        ew[0] = {6'h00, 32'd0};
        ew[1] = {6'h03, 14'b0, v.n};
        ew[2] = {6'h04, 14'b0, v.m};
        ew[3] = {6'h05, 14'b0, v.c0};
        ew[4] = {6'h02, 32'd1};
        chk("write_count", wq.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("write_%0d", i), (i < wq.size()) ? wq[i] : 38'h0, ew[i]);
    endtask

    vec_t tbl[8];

    initial begin
        //          n         m         c0        slo shi lvl fall rise poke err off
        tbl[0] = '{18'h10101, 18'h00A0A, 18'h00303, 0, 0, 1, 5,   200, 0,  0, 208};
        tbl[1] = '{18'h10101, 18'h00A0A, 18'h00303, 3, 3, 1, 5,   200, 0,  0, 208};
        tbl[2] = '{18'h3C0F0, 18'h01234, 18'h2FFFF, 0, 0, 1, 0,   0,   0,  0, 1025};
        tbl[3] = '{18'h00001, 18'h00002, 18'h00004, 1, 1, 0, 0,   0,   0,  1, 301};
        tbl[4] = '{18'h12345, 18'h0BEEF, 18'h20000, 2, 2, 1, 2,   1,   1,  0, 6};
        tbl[5] = '{18'h11111, 18'h22222, 18'h33333, 0, 0, 1, 10,  300, 0,  0, 313};
        tbl[6] = '{18'h0F0F0, 18'h30303, 18'h00FF0, 0, 0, 1, 10,  301, 0,  1, 313};
        tbl[7] = '{18'h2AAAA, 18'h15555, 18'h00100, 0, 1, 1, 7,   50,  1,  0, 60};

        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_write", mgmt_write, 0);
        chk("reset_addr", mgmt_addr, 0);
        chk("reset_wdata", mgmt_wdata, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run(tbl[i]);

        // Reset asserted while the M-word write is stalled
        begin
            int seen;
            wq.delete();
            start_valid = 1'b0;
            stall_lo = 10; stall_hi = 10; lvl0 = 1'b1;
            repeat (4) @(negedge clk);
            #1;
            cfg_n = 18'h1; cfg_m = 18'h2; cfg_c0 = 18'h3;
            cfg_req = 1'b1;
            @(negedge clk); #1;
            cfg_req = 1'b0;
            seen = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk); #1;
                if (mgmt_write && mgmt_addr == 6'h04 && mgmt_waitreq) begin seen = 1; break; end
            end
            chk("reached_wr_m_stalled", seen, 1);
            rst_n = 1'b0;
            #1;
            chk("reset_drops_write", mgmt_write, 0);
            chk("reset_drops_busy", busy, 0);
            repeat (2) @(negedge clk);
            #1;
            rst_n = 1'b1;
            @(negedge clk); #1;
            chk("post_reset_busy", busy, 0);
            chk("post_reset_done", done, 0);
            chk("post_reset_err", err, 0);
            chk("post_reset_write", mgmt_write, 0);
        end

        for (int r = 0; r < 12; r++) begin
            vec_t v;
            bit   e;
            int   o;
            v.n = 18'($urandom); v.m = 18'($urandom); v.c0 = 18'($urandom);
            v.stall_lo = 0;
            v.stall_hi = $urandom_range(3, 0);
            v.lvl0 = ($urandom_range(7, 0) != 0);
            v.fall = $urandom_range(40, 0);
            v.rise = $urandom_range(350, 0);
            v.poke = $urandom_range(1, 0);
            predict(v.lvl0, v.fall, v.rise, e, o);
            v.exp_err = e;
            v.exp_off = o;
            run(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
